// File: rtl/demux_select_programmer.sv
// AXI4-Lite initiator that writes a demux select value, commits it, and optionally reads it back.
// One request in flight at a time; a one-cycle status pulse reports the outcome.
module demux_select_programmer #(
    parameter int unsigned M_COUNT       = 2,
    parameter int unsigned SELECT_SIZE   = $clog2(M_COUNT),
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter logic [11:0] SELECT_OFFSET = 12'h000,
    parameter logic [11:0] COMMIT_OFFSET = 12'h004,
    parameter bit          VERIFY        = 1'b1,
    parameter int unsigned STALL_CYCLES  = 1024
) (
    input  logic                   axil_aclk,
    input  logic                   axil_areset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SELECT_SIZE-1:0] req_select,
    output logic                   done_valid,
    output logic [1:0]             done_status,
    output logic                   stall,
    output logic                   m_axil_awvalid,
    output logic [31:0]            m_axil_awaddr,
    input  logic                   m_axil_awready,
    output logic                   m_axil_wvalid,
    output logic [31:0]            m_axil_wdata,
    output logic [3:0]             m_axil_wstrb,
    input  logic                   m_axil_wready,
    input  logic                   m_axil_bvalid,
    input  logic [1:0]             m_axil_bresp,
    output logic                   m_axil_bready,
    output logic                   m_axil_arvalid,
    output logic [31:0]            m_axil_araddr,
    input  logic                   m_axil_arready,
    input  logic                   m_axil_rvalid,
    input  logic [31:0]            m_axil_rdata,
    input  logic [1:0]             m_axil_rresp,
    output logic                   m_axil_rready
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWrSel  = 3'd1;
    localparam logic [2:0] StWrSelB = 3'd2;
    localparam logic [2:0] StWrCom  = 3'd3;
    localparam logic [2:0] StWrComB = 3'd4;
    localparam logic [2:0] StRdSel  = 3'd5;
    localparam logic [2:0] StRdDat  = 3'd6;
    localparam logic [2:0] StDone   = 3'd7;

    localparam logic [31:0] SelAddr = BASE_ADDR + {20'h0, SELECT_OFFSET};
    localparam logic [31:0] ComAddr = BASE_ADDR + {20'h0, COMMIT_OFFSET};

    localparam int unsigned CntW = $clog2(STALL_CYCLES + 1);
    localparam logic [CntW-1:0] StallMax = CntW'(STALL_CYCLES);

    logic [2:0]      state_q, state_d;
    logic [31:0]     sel_q, sel_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic [1:0]      status_q, status_d;
    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
    logic            stall_q, stall_d;

    logic aw_ok, w_ok, waiting, handshake;
    logic unused_rdata;

    assign unused_rdata = ^m_axil_rdata[31:SELECT_SIZE];

    assign req_ready      = (state_q == StIdle) && !axil_areset;
    assign done_valid     = (state_q == StDone);
    assign done_status    = status_q;
    assign stall          = stall_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_awaddr  = (state_q == StWrCom) ? ComAddr : SelAddr;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_wdata   = (state_q == StWrCom) ? 32'h1 : sel_q;
    assign m_axil_wstrb   = 4'hF;
    assign m_axil_bready  = (state_q == StWrSelB) || (state_q == StWrComB);
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_araddr  = SelAddr;
    assign m_axil_rready  = (state_q == StRdDat);

    // A channel counts as complete once its valid has dropped or it handshakes now.
    assign aw_ok = !awvalid_q || m_axil_awready;
    assign w_ok  = !wvalid_q || m_axil_wready;

    assign waiting = (awvalid_q && !m_axil_awready) || (wvalid_q && !m_axil_wready) ||
                     (m_axil_bready && !m_axil_bvalid) || (arvalid_q && !m_axil_arready) ||
                     (m_axil_rready && !m_axil_rvalid);
    assign handshake = (awvalid_q && m_axil_awready) || (wvalid_q && m_axil_wready) ||
                       (m_axil_bready && m_axil_bvalid) || (arvalid_q && m_axil_arready) ||
                       (m_axil_rready && m_axil_rvalid);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        status_d  = status_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    sel_d     = 32'(req_select);
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StWrSel;
                end
            end
            StWrSel, StWrCom: begin
                if (m_axil_awready) awvalid_d = 1'b0;
                if (m_axil_wready) wvalid_d = 1'b0;
                if (aw_ok && w_ok) state_d = (state_q == StWrSel) ? StWrSelB : StWrComB;
            end
            StWrSelB: begin
                if (m_axil_bvalid) begin
                    if (m_axil_bresp != 2'b00) begin
                        status_d = 2'd1;
                        state_d  = StDone;
                    end else begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrCom;
                    end
                end
            end
            StWrComB: begin
                if (m_axil_bvalid) begin
                    if (m_axil_bresp != 2'b00) begin
                        status_d = 2'd1;
                        state_d  = StDone;
                    end else if (VERIFY) begin
                        arvalid_d = 1'b1;
                        state_d   = StRdSel;
                    end else begin
                        status_d = 2'd0;
                        state_d  = StDone;
                    end
                end
            end
            StRdSel: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdDat;
                end
            end
            StRdDat: begin
                if (m_axil_rvalid) begin
                    if (m_axil_rresp != 2'b00) begin
                        status_d = 2'd2;
                    end else if (m_axil_rdata[SELECT_SIZE-1:0] != sel_q[SELECT_SIZE-1:0]) begin
                        status_d = 2'd3;
                    end else begin
                        status_d = 2'd0;
                    end
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating wait counter; any handshake restarts it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (handshake || !waiting) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != StallMax) begin
            stall_cnt_d = stall_cnt_q + CntW'(1);
        end
        stall_d = stall_q || (stall_cnt_q == StallMax);
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_areset) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            status_q    <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            status_q    <= status_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_demux_select_programmer.sv
// Directed bench for demux_select_programmer with a configurable AXI4-Lite slave model.
module tb_demux_select_programmer;

    logic        clk = 1'b0;
    logic        axil_areset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [0:0]  req_select = '0;
    logic        done_valid;
    logic [1:0]  done_status;
    logic        stall;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    // slave configuration
    int          aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          rdata_force = 1'b0;
    logic [31:0] rdata_val = '0;

    // slave state
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit          aw_got = 0, w_got = 0, r_pend = 0;
    logic [31:0] aw_hold = '0, w_hold = '0, mem_sel = '0;
    logic [31:0] aw_log[$], w_log[$], ar_log[$];
    int          done_cnt = 0;

    always #5 clk = ~clk;

    demux_select_programmer dut (
        .axil_aclk      (clk),
        .axil_areset    (axil_areset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_select     (req_select),
        .done_valid     (done_valid),
        .done_status    (done_status),
        .stall          (stall),
        .m_axil_awvalid (awvalid),
        .m_axil_awaddr  (awaddr),
        .m_axil_awready (awready),
        .m_axil_wvalid  (wvalid),
        .m_axil_wdata   (wdata),
        .m_axil_wstrb   (wstrb),
        .m_axil_wready  (wready),
        .m_axil_bvalid  (bvalid),
        .m_axil_bresp   (bresp),
        .m_axil_bready  (bready),
        .m_axil_arvalid (arvalid),
        .m_axil_araddr  (araddr),
        .m_axil_arready (arready),
        .m_axil_rvalid  (rvalid),
        .m_axil_rdata   (rdata),
        .m_axil_rresp   (rresp),
        .m_axil_rready  (rready)
    );

    assign awready = (aw_cnt >= aw_delay);
    assign wready  = (w_cnt >= w_delay);
    assign bvalid  = aw_got && w_got && (b_cnt >= b_delay);
    assign bresp   = bresp_cfg;
    assign arready = 1'b1;
    assign rvalid  = r_pend;
    assign rdata   = rdata_force ? rdata_val : mem_sel;
    assign rresp   = rresp_cfg;

    always @(posedge clk) begin
        if (axil_areset) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            aw_got <= 0; w_got <= 0; r_pend <= 0;
        end else begin
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (awvalid && awready) begin
                aw_cnt <= 0; aw_got <= 1; aw_hold <= awaddr; aw_log.push_back(awaddr);
            end
            if (wvalid && !wready) w_cnt <= w_cnt + 1;
            if (wvalid && wready) begin
                w_cnt <= 0; w_got <= 1; w_hold <= wdata; w_log.push_back(wdata);
            end
            if (aw_got && w_got) begin
                if (bvalid && bready) begin
                    aw_got <= 0; w_got <= 0; b_cnt <= 0;
                    if (aw_hold == 32'h0 && bresp_cfg == 2'b00) mem_sel <= w_hold;
                end else if (!bvalid) begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (arvalid && arready) begin
                r_pend <= 1; ar_log.push_back(araddr);
            end
            if (rvalid && rready) r_pend <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pending valids must hold value and payload until their handshake.
    bit          aw_pend = 0, w_pend = 0;
    logic [31:0] aw_prev = '0, w_prev = '0;
    always @(negedge clk) begin
        if (done_valid) done_cnt++;
        if (!axil_areset && aw_pend) begin
            check("aw_hold_valid", 32'(awvalid), 32'd1);
            check("aw_hold_addr", awaddr, aw_prev);
        end
        if (!axil_areset && w_pend) begin
            check("w_hold_valid", 32'(wvalid), 32'd1);
            check("w_hold_data", wdata, w_prev);
        end
        aw_pend = !axil_areset && awvalid && !awready;
        w_pend  = !axil_areset && wvalid && !wready;
        aw_prev = awaddr;
        w_prev  = wdata;
    end

    // Latency counts the accept cycle and the done cycle inclusively.
    task automatic run_req(input logic [0:0] sel, output logic [1:0] st, output int lat);
        int n;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_select = sel;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 2;
        n = 0;
        while (!done_valid && n < 5000) begin
            @(negedge clk);
            lat++;
            n++;
        end
        check("done_seen", 32'(done_valid), 32'd1);
        st = done_status;
        @(negedge clk);
        check("done_one_cycle", 32'(done_valid), 32'd0);
        check("req_ready_after_done", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [1:0] st;
        int         lat;
        int         n;
        int         dc;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_status", 32'(done_status), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 axil_areset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_wstrb", 32'(wstrb), 32'hF);

        // zero-wait full sequence
        run_req(1'b1, st, lat);
        check("t1_status", 32'(st), 32'd0);
        check("t1_latency", lat, 32'd8);
        check("t1_aw_count", aw_log.size(), 32'd2);
        check("t1_aw0", aw_log[0], 32'h0);
        check("t1_aw1", aw_log[1], 32'h4);
        check("t1_w0", w_log[0], 32'h1);
        check("t1_w1", w_log[1], 32'h1);
        check("t1_ar_count", ar_log.size(), 32'd1);
        check("t1_ar0", ar_log[0], 32'h0);

        // select value 0
        aw_log.delete(); w_log.delete(); ar_log.delete();
        run_req(1'b0, st, lat);
        check("t1b_status", 32'(st), 32'd0);
        check("t1b_w0", w_log[0], 32'h0);

        // write error on select: no commit
        aw_log.delete(); w_log.delete(); ar_log.delete();
        bresp_cfg = 2'b10;
        run_req(1'b1, st, lat);
        bresp_cfg = 2'b00;
        check("t2_status", 32'(st), 32'd1);
        check("t2_aw_count", aw_log.size(), 32'd1);
        check("t2_ar_count", ar_log.size(), 32'd0);
        check("t2_latency", lat, 32'd4);

        // readback mismatch, upper bits ignored, read error
        rdata_force = 1'b1;
        rdata_val   = 32'h0;
        run_req(1'b1, st, lat);
        check("t3_mismatch", 32'(st), 32'd3);
        rdata_val = 32'hFFFF_FFF1;
        run_req(1'b1, st, lat);
        check("t3_upper_ignored", 32'(st), 32'd0);
        rdata_force = 1'b0;
        rresp_cfg   = 2'b11;
        run_req(1'b1, st, lat);
        check("t3_rresp_err", 32'(st), 32'd2);
        rresp_cfg = 2'b00;

        // AW before W, then W before AW
        aw_log.delete(); w_log.delete();
        aw_delay = 0; w_delay = 3;
        run_req(1'b1, st, lat);
        check("t4a_status", 32'(st), 32'd0);
        check("t4a_aw_count", aw_log.size(), 32'd2);
        check("t4a_w_count", w_log.size(), 32'd2);
        check("t4a_latency", lat, 32'd14);
        aw_log.delete(); w_log.delete();
        aw_delay = 3; w_delay = 0;
        run_req(1'b0, st, lat);
        check("t4b_status", 32'(st), 32'd0);
        check("t4b_aw_count", aw_log.size(), 32'd2);
        check("t4b_w_count", w_log.size(), 32'd2);
        check("t4b_w0", w_log[0], 32'h0);
        check("t4b_latency", lat, 32'd14);
        aw_delay = 0; w_delay = 0;

        // long write-response wait sets sticky stall
        check("t5_stall_before", 32'(stall), 32'd0);
        b_delay = 1029;
        run_req(1'b1, st, lat);
        b_delay = 0;
        check("t5_status", 32'(st), 32'd0);
        check("t5_latency", lat, 32'd2066);
        check("t5_stall", 32'(stall), 32'd1);
        repeat (5) @(negedge clk);
        check("t5_stall_sticky", 32'(stall), 32'd1);

        // reset while commit AW is pending
        aw_log.delete();
        aw_delay = 10;
        @(negedge clk);
        req_select = 1'b1;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(awvalid && aw_log.size() == 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_commit", 32'(awvalid && aw_log.size() == 1), 32'd1);
        dc = done_cnt;
        @(posedge clk);
        #1 axil_areset = 1'b1;
        @(posedge clk);
        #1 axil_areset = 1'b0;
        @(negedge clk);
        check("t6_awvalid", 32'(awvalid), 32'd0);
        check("t6_wvalid", 32'(wvalid), 32'd0);
        check("t6_idle", 32'(req_ready), 32'd1);
        check("t6_stall_cleared", 32'(stall), 32'd0);
        aw_delay = 0;
        repeat (10) @(negedge clk);
        check("t6_no_done", done_cnt, dc);
        run_req(1'b1, st, lat);
        check("t6_after_status", 32'(st), 32'd0);
        check("t6_after_latency", lat, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
